// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer: owns the fetch PC, issues one word request at a
// time to a variable-latency instruction memory, buffers responses in a small
// in-order queue and honours D-stage redirects with a single delay slot.
//   clk, reset (async, active low)
//   stall, redirect, next_pc      : decode-side hold / control-transfer target
//   im_req, im_addr               : memory request (held stable until im_ack)
//   im_ack, im_rdata              : memory response for the outstanding request
//   F_valid, F_PC, F_instr        : queue head presented to decode
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] next_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        F_valid,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        drop_addr_q, drop_addr_d;
  logic [31:0]        tgt_q, tgt_d;
  logic               pend_q, pend_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  fq_entry_t          fifo_q [DEPTH];

  logic               head_valid;
  logic               pop_c;
  logic               push_c;
  logic               redir_take;
  logic               ack_req;
  logic [31:0]        next_pc_w;
  fq_entry_t          push_entry;

  assign head_valid = (count_q != '0);
  assign pop_c      = head_valid && !stall;
  // A redirect while one is already pending cannot legally occur; drop it.
  assign redir_take = redirect && !stall && !pend_q;
  assign ack_req    = (state_q == REQ) && im_ack;
  assign next_pc_w  = {next_pc[31:2], 2'b00};
  assign push_entry = '{pc: fetch_pc_q, instr: im_rdata};

  // Next-state: queue bookkeeping, fetch PC update and request sequencing.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    tgt_d       = tgt_q;
    pend_d      = pend_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    push_c      = 1'b0;

    if (redir_take && head_valid) begin
      // Head is the delay slot and pops into D; everything behind it is
      // wrong-path, as is any response arriving this cycle.
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      fetch_pc_d = next_pc_w;
    end else begin
      push_c = ack_req;
      if (push_c) begin
        fetch_pc_d = pend_q ? tgt_q : fetch_pc_q + 32'd4;
        pend_d     = 1'b0;
      end
      // Delay slot not yet returned: it is the next accepted response.
      if (redir_take) begin
        if (push_c) begin
          fetch_pc_d = next_pc_w;
        end else begin
          pend_d = 1'b1;
          tgt_d  = next_pc_w;
        end
      end
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    case (state_q)
      IDLE: begin
        if (count_d < CNT_W'(DEPTH)) state_d = REQ;
      end
      REQ: begin
        if (im_ack) begin
          state_d = (count_d < CNT_W'(DEPTH)) ? REQ : IDLE;
        end else if (redir_take && head_valid) begin
          // Outstanding request is now stale; keep presenting its address.
          state_d     = DROP;
          drop_addr_d = fetch_pc_q;
        end
      end
      DROP: begin
        if (im_ack) state_d = (count_d < CNT_W'(DEPTH)) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and queue registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      tgt_q       <= '0;
      pend_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      tgt_q       <= tgt_d;
      pend_q      <= pend_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      if (push_c) fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  assign im_req  = (state_q != IDLE);
  assign im_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  assign F_valid = head_valid;
  assign F_PC    = head_valid ? fifo_q[rd_ptr_q].pc : RESET_PC;
  assign F_instr = head_valid ? fifo_q[rd_ptr_q].instr : 32'd0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: random-latency memory, random stall/redirect from a
// decode model that predicts the delivered program-order PC stream.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] next_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        F_valid;
  logic [31:0] F_PC;
  logic [31:0] F_instr;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model
  bit          mem_active;
  logic [31:0] mem_addr;
  int unsigned mem_age, mem_lat;
  int unsigned lat_min = 1, lat_max = 1;

  // decode / program-order model
  logic [31:0] exp_next, tgt;
  bit          tgt_pend, d_can_branch;
  int          pops = 0;
  int unsigned stall_pct = 0, redir_pct = 0;
  bit          wrap_tgts = 1'b0, force_stall = 1'b0;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .redirect (redirect),
    .next_pc  (next_pc),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_rdata (im_rdata),
    .F_valid  (F_valid),
    .F_PC     (F_PC),
    .F_instr  (F_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic model_reset();
    exp_next     = RESET_PC;
    tgt_pend     = 1'b0;
    d_can_branch = 1'b0;
    mem_active   = 1'b0;
  endtask

  // One clock: observe at negedge, check, then drive inputs for next posedge.
  task automatic cycle();
    logic [31:0] r;
    bit acc_redir, do_pop;
    @(negedge clk);
    if (!F_valid) begin
      check("empty_pc", F_PC, RESET_PC);
      check("empty_instr", F_instr, 32'd0);
    end
    if (im_req) check("addr_align", 32'(im_addr[1:0]), 32'd0);

    if (mem_active) begin
      mem_age++;
      check("req_hold", 32'(im_req), 32'd1);
      check("addr_hold", im_addr, mem_addr);
    end else if (im_req) begin
      mem_active = 1'b1;
      mem_addr   = im_addr;
      mem_age    = 0;
      mem_lat    = $urandom_range(lat_max, lat_min);
    end
    if (mem_active && mem_age >= mem_lat) begin
      im_ack     = 1'b1;
      im_rdata   = mem_word(mem_addr);
      mem_active = 1'b0;
    end else begin
      im_ack   = 1'b0;
      im_rdata = $urandom();
    end

    stall    = force_stall || ($urandom_range(99, 0) < stall_pct);
    redirect = 1'b0;
    r        = $urandom();
    next_pc  = wrap_tgts ? (32'hFFFF_FFF0 | (r & 32'h0000_000C)) : (r & 32'hFFFF_FFFC);
    if (d_can_branch && ($urandom_range(99, 0) < redir_pct)) redirect = 1'b1;
    else if (stall && ($urandom_range(9, 0) == 0)) redirect = 1'b1;

    acc_redir = redirect && !stall;
    do_pop    = F_valid && !stall;
    if (acc_redir) begin
      tgt_pend     = 1'b1;
      tgt          = next_pc;
      d_can_branch = 1'b0;
    end
    if (do_pop) begin
      pops++;
      check("f_pc", F_PC, exp_next);
      check("f_instr", F_instr, mem_word(exp_next));
      if (tgt_pend) begin
        exp_next     = tgt;
        tgt_pend     = 1'b0;
        d_can_branch = 1'b0;
      end else begin
        exp_next     = exp_next + 32'd4;
        d_can_branch = 1'b1;
      end
    end
  endtask

  task automatic run_phase(input string name, input int n, input int unsigned lmin,
                           input int unsigned lmax, input int unsigned spct,
                           input int unsigned rpct, input bit wrap);
    int p0;
    lat_min   = lmin;
    lat_max   = lmax;
    stall_pct = spct;
    redir_pct = rpct;
    wrap_tgts = wrap;
    p0 = pops;
    repeat (n) cycle();
    check({name, "_progress"}, 32'(pops > p0), 32'd1);
  endtask

  initial begin
    int p0, k;
    reset    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    next_pc  = '0;
    im_ack   = 1'b0;
    im_rdata = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(F_valid), 32'd0);
    check("rst_pc", F_PC, RESET_PC);
    check("rst_instr", F_instr, 32'd0);
    check("rst_req", 32'(im_req), 32'd0);

    // Stalled start: queue fills with 3000/3004, next address waits unissued.
    force_stall = 1'b1;
    stall       = 1'b1;
    reset       = 1'b1;
    @(posedge clk); #1;
    check("first_req", 32'(im_req), 32'd1);
    check("first_addr", im_addr, RESET_PC);
    repeat (8) cycle();
    check("full_req", 32'(im_req), 32'd0);
    check("full_addr", im_addr, 32'h0000_3008);
    check("full_valid", 32'(F_valid), 32'd1);
    check("full_head", F_PC, 32'h0000_3000);
    force_stall = 1'b0;

    p0 = pops;
    run_phase("seq", 100, 1, 1, 0, 0, 1'b0);
    check("seq_rate", 32'((pops - p0) >= 45), 32'd1);
    run_phase("mixed", 3000, 1, 4, 30, 20, 1'b0);
    run_phase("wrap", 500, 1, 4, 20, 15, 1'b1);

    // Async reset with a request outstanding and the queue occupied.
    force_stall = 1'b1;
    lat_min = 2;
    lat_max = 3;
    k = 0;
    while (!(F_valid && im_req) && k < 100) begin
      cycle();
      k++;
    end
    check("rst_setup", 32'(F_valid && im_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(F_valid), 32'd0);
    check("arst_pc", F_PC, RESET_PC);
    check("arst_instr", F_instr, 32'd0);
    check("arst_req", 32'(im_req), 32'd0);
    force_stall = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    im_ack      = 1'b1;
    im_rdata    = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) @(negedge clk);
    check("arst_hold_req", 32'(im_req), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("restart_req", 32'(im_req), 32'd1);
    check("restart_addr", im_addr, RESET_PC);
    run_phase("post_rst", 300, 1, 4, 25, 20, 1'b0);

    check("total_pops", 32'(pops > 1000), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
